idli_sqi_ctrl_m: RTL and testbench
==================================

# idli_sqi_ctrl_m

SQI memory controller sitting directly downstream of the idli core's memory request logic and driving the external SQI SRAM pins (SCK, CS, SIO[3:0], IO direction). It turns single 16-bit word read/write requests into complete SQI transactions (command, 24-bit address, dummy, data nibbles), MSB nibble first. It returns read data with a one-cycle response pulse. All pin outputs are registered.

## Interface
- CMD_RD, 8'h03, SQI read command byte
- CMD_WR, 8'h02, SQI write command byte
- DUMMY_NIB, 2, dummy nibbles between address and read data (reads only)

- i_sqi_gck  in  1  core clock; the only clock
- i_sqi_rst_n  in  1  reset, asynchronous, active-low
- i_sqi_req_vld  in  1  request valid
- i_sqi_req_wr  in  1  1 = write, 0 = read
- i_sqi_req_addr  in  16  word address
- i_sqi_req_wdata  in  16  write data
- o_sqi_req_rdy  out  1  request accepted when vld && rdy
- o_sqi_rsp_vld  out  1  one-cycle pulse at transaction completion; no backpressure
- o_sqi_rsp_rdata  out  16  read data; updated only by reads
- o_sqi_sck  out  1  SQI serial clock
- o_sqi_cs  out  1  SQI chip select, active-low
- o_sqi_io_mode  out  sqi_io_mode_t  SIO direction
- i_sqi_sio  in  4  SIO inputs from memory
- o_sqi_sio  out  4  SIO outputs to memory

## Operation
- Reset values: o_sqi_cs=1, o_sqi_sck=0, o_sqi_io_mode=SQI_IO_MODE_OUT, o_sqi_sio=0, o_sqi_rsp_vld=0, o_sqi_rsp_rdata=0. State=IDLE, so o_sqi_req_rdy=1.
- States: IDLE, CMD (2 nibbles), ADDR (6 nibbles), DUMMY (DUMMY_NIB nibbles, reads only), DATA (4 nibbles), DONE, plus HOLD and CSH under the macro.
- o_sqi_req_rdy = (state==IDLE) || (state==HOLD). It does not depend on the request inputs.
- On acceptance, latch wr, addr and wdata. Byte address = {7'b0, addr, 1'b0}.
- Each nibble takes two cycles:
  - phase 0: SCK=0, drive o_sqi_sio.
  - phase 1: SCK=1; the memory samples on the SCK rising edge.
  - Reads: capture i_sqi_sio on the gck edge that ends phase 1.
- o_sqi_io_mode:
  - OUT during CMD and ADDR, and for all write nibbles.
  - IN from the first DUMMY nibble through the end of DATA.
  - Returns to OUT in DONE.
- DONE: CS=1, SCK=0, o_sqi_rsp_vld=1 for one cycle. Reads present the assembled word on rdata in this same cycle. Next state IDLE.
- Reset mid-transaction: CS deasserts immediately (asynchronous). No response is issued and the memory transaction is abandoned.

## Timing
- Acceptance is cycle 0. Nibble k occupies cycles 2k+1 (SCK low) and 2k+2 (SCK high). CS is low from cycle 1.
- Write: 12 nibbles, cycles 1–24. DONE in cycle 25. rdy=1 again in cycle 26.
- Read (DUMMY_NIB=2): 14 nibbles, cycles 1–28. DONE with rsp_vld and data in cycle 29. rdy=1 in cycle 30.
- Minimum CS-high time between transactions: 2 cycles (DONE, IDLE with immediate acceptance).

## Configuration
- Macro `IDLI_SQI_SEQ_EN`: sequential continuation.
- With the macro defined:
  - After DATA, enter HOLD instead of DONE, with CS held low and SCK=0. rsp_vld pulses in the first HOLD cycle.
  - In HOLD, a request with the same wr value and addr == previous addr + 1 is accepted and goes straight to DATA. No command or address is sent.
  - Any other request is accepted, passes through CSH (CS=1 for one cycle), then starts at CMD.
  - addr 16'hFFFF followed by 16'h0000 is not contiguous and takes the restart path.
  - With no request, HOLD persists indefinitely.
- Without the macro: HOLD and CSH do not exist, and every transaction ends through DONE.

## Structure
- Add SQI_IO_MODE_IN alongside SQI_IO_MODE_OUT in sqi_io_mode_t in idli_pkg.
- The state enum (sqi_ctrl_state_t) also belongs in idli_pkg.
- Single module, no sub-module. The nibble counter, phase bit and 16-bit shift register stay inline.

## Test plan
- Reset: check every output at its reset value; assert reset in cycle 10 of a read and check CS=1 immediately and no rsp_vld.
- Write addr=16'h1234, wdata=16'hBEEF: SIO nibble sequence 0,2,0,0,2,4,6,8,B,E,E,F on SCK rises; io_mode OUT throughout; rsp_vld in cycle 25.
- Read addr=16'h0001 with the memory model returning 16'hCAFE: command nibbles 0,3; address 0,0,0,0,0,2; io_mode IN from cycle 17; rsp_vld and rdata=16'hCAFE in cycle 29.
- Back-to-back write then read, with vld held high: the second acceptance occurs in the cycle after DONE, and CS is high for 2 cycles between them.
- With `IDLI_SQI_SEQ_EN`, read 16'h0010 then 16'h0011: the second read emits only 4 DATA nibbles with CS continuously low. A third read to 16'h0005 passes through CSH then CMD.
- With `IDLI_SQI_SEQ_EN`, write 16'hFFFF then write 16'h0000: the restart path is taken, and the full address 0,0,0,0,0,0 is sent.

Source files
------------

// File: rtl/idli_pkg.sv
// Shared types and constants for the idli core. The SQI controller uses the
// io-direction type, its state encoding and the SQI command bytes.
package idli_pkg;

  localparam logic [7:0] CMD_RD    = 8'h03;
  localparam logic [7:0] CMD_WR    = 8'h02;
  localparam int         DUMMY_NIB = 2;

  typedef enum logic {
    SQI_IO_MODE_OUT = 1'b0,
    SQI_IO_MODE_IN  = 1'b1
  } sqi_io_mode_t;

  typedef enum logic [2:0] {
    SQI_ST_IDLE  = 3'd0,
    SQI_ST_CMD   = 3'd1,
    SQI_ST_ADDR  = 3'd2,
    SQI_ST_DUMMY = 3'd3,
    SQI_ST_DATA  = 3'd4,
    SQI_ST_DONE  = 3'd5,
    SQI_ST_HOLD  = 3'd6,
    SQI_ST_CSH   = 3'd7
  } sqi_ctrl_state_t;

  // Index of the final nibble in each nibble-carrying state.
  function automatic logic [2:0] sqi_nib_last(input sqi_ctrl_state_t st);
    case (st)
      SQI_ST_CMD:   return 3'd1;
      SQI_ST_ADDR:  return 3'd5;
      SQI_ST_DUMMY: return 3'(DUMMY_NIB - 1);
      default:      return 3'd3;
    endcase
  endfunction

endpackage

// File: rtl/idli_sqi_ctrl_m.sv
// SQI SRAM controller: one 16-bit word per request, nibble-serial, MSB first.
// Define IDLI_SQI_SEQ_EN to keep CS low after a transfer and stream contiguous words.
module idli_sqi_ctrl_m
  import idli_pkg::*;
(
  input  logic         i_sqi_gck,
  input  logic         i_sqi_rst_n,
  input  logic         i_sqi_req_vld,
  input  logic         i_sqi_req_wr,
  input  logic [15:0]  i_sqi_req_addr,
  input  logic [15:0]  i_sqi_req_wdata,
  output logic         o_sqi_req_rdy,
  output logic         o_sqi_rsp_vld,
  output logic [15:0]  o_sqi_rsp_rdata,
  output logic         o_sqi_sck,
  output logic         o_sqi_cs,
  output sqi_io_mode_t o_sqi_io_mode,
  input  logic [3:0]   i_sqi_sio,
  output logic [3:0]   o_sqi_sio
);

  sqi_ctrl_state_t state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic            ph_q, ph_d;
  logic            wr_q, wr_d;
  logic [15:0]     addr_q, addr_d;
  logic [15:0]     shreg_q, shreg_d;
  logic [15:0]     rdata_q, rdata_d;
  logic            rsp_vld_q, rsp_vld_d;
  logic            cs_q, cs_d;
  logic            sck_q, sck_d;
  logic [3:0]      sio_q, sio_d;
  sqi_io_mode_t    mode_q, mode_d;
  logic            nib_st_d;
  logic [7:0]      cmd_d;
  logic [23:0]     baddr_d;
`ifdef IDLI_SQI_SEQ_EN
  logic            contig;

  // 17-bit compare so FFFF -> 0000 does not count as the next word.
  assign contig = (i_sqi_req_wr == wr_q) &&
                  ({1'b0, i_sqi_req_addr} == ({1'b0, addr_q} + 17'd1));
`endif

  assign o_sqi_req_rdy = (state_q == SQI_ST_IDLE) || (state_q == SQI_ST_HOLD);

  always_comb begin : next_state
    state_d   = state_q;
    cnt_d     = cnt_q;
    ph_d      = ph_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    shreg_d   = shreg_q;
    rdata_d   = rdata_q;
    rsp_vld_d = 1'b0;
    case (state_q)
      SQI_ST_IDLE: if (i_sqi_req_vld) state_d = SQI_ST_CMD;
      SQI_ST_CMD, SQI_ST_ADDR, SQI_ST_DUMMY, SQI_ST_DATA: begin
        ph_d = ~ph_q;
        if (ph_q) begin
          cnt_d = cnt_q + 3'd1;
          // Read nibbles are taken on the edge that ends the SCK-high phase.
          if (state_q == SQI_ST_DATA)
            shreg_d = {shreg_q[11:0], wr_q ? 4'h0 : i_sqi_sio};
          if (cnt_q == sqi_nib_last(state_q)) begin
            cnt_d = '0;
            case (state_q)
              SQI_ST_CMD:   state_d = SQI_ST_ADDR;
              SQI_ST_ADDR:  state_d = wr_q ? SQI_ST_DATA : SQI_ST_DUMMY;
              SQI_ST_DUMMY: state_d = SQI_ST_DATA;
              default: begin
                if (!wr_q) rdata_d = shreg_d;
                rsp_vld_d = 1'b1;
`ifdef IDLI_SQI_SEQ_EN
                state_d = SQI_ST_HOLD;
`else
                state_d = SQI_ST_DONE;
`endif
              end
            endcase
          end
        end
      end
`ifdef IDLI_SQI_SEQ_EN
      SQI_ST_HOLD: if (i_sqi_req_vld) state_d = contig ? SQI_ST_DATA : SQI_ST_CSH;
      SQI_ST_CSH:  state_d = SQI_ST_CMD;
`endif
      default: state_d = SQI_ST_IDLE;
    endcase
    if (i_sqi_req_vld && o_sqi_req_rdy) begin
      wr_d    = i_sqi_req_wr;
      addr_d  = i_sqi_req_addr;
      shreg_d = i_sqi_req_wdata;
      cnt_d   = '0;
      ph_d    = 1'b0;
    end
  end

  // Pins are registered from the next-state view so they line up with state_q.
  always_comb begin : pin_next
    nib_st_d = (state_d == SQI_ST_CMD) || (state_d == SQI_ST_ADDR) ||
               (state_d == SQI_ST_DUMMY) || (state_d == SQI_ST_DATA);
    cmd_d    = wr_d ? CMD_WR : CMD_RD;
    baddr_d  = {7'b0, addr_d, 1'b0};
    cs_d     = ~(nib_st_d || (state_d == SQI_ST_HOLD));
    sck_d    = nib_st_d && ph_d;
    sio_d    = '0;
    case (state_d)
      SQI_ST_CMD:  sio_d = cnt_d[0] ? cmd_d[3:0] : cmd_d[7:4];
      SQI_ST_ADDR: sio_d = 4'(baddr_d >> (5'd20 - {cnt_d, 2'b00}));
      SQI_ST_DATA: if (wr_d) sio_d = shreg_d[15:12];
      default: ;
    endcase
    // A read keeps the bus released through HOLD since the memory may still drive it.
    mode_d = ((state_d == SQI_ST_DUMMY) ||
              (((state_d == SQI_ST_DATA) || (state_d == SQI_ST_HOLD)) && !wr_d))
             ? SQI_IO_MODE_IN : SQI_IO_MODE_OUT;
  end

  always_ff @(posedge i_sqi_gck or negedge i_sqi_rst_n) begin
    if (!i_sqi_rst_n) begin
      state_q   <= SQI_ST_IDLE;
      cnt_q     <= '0;
      ph_q      <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      shreg_q   <= '0;
      rdata_q   <= '0;
      rsp_vld_q <= 1'b0;
      cs_q      <= 1'b1;
      sck_q     <= 1'b0;
      sio_q     <= '0;
      mode_q    <= SQI_IO_MODE_OUT;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ph_q      <= ph_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      shreg_q   <= shreg_d;
      rdata_q   <= rdata_d;
      rsp_vld_q <= rsp_vld_d;
      cs_q      <= cs_d;
      sck_q     <= sck_d;
      sio_q     <= sio_d;
      mode_q    <= mode_d;
    end
  end

  assign o_sqi_rsp_vld   = rsp_vld_q;
  assign o_sqi_rsp_rdata = rdata_q;
  assign o_sqi_cs        = cs_q;
  assign o_sqi_sck       = sck_q;
  assign o_sqi_sio       = sio_q;
  assign o_sqi_io_mode   = mode_q;

endmodule

// File: tb/tb_idli_sqi_ctrl_m.sv
// Bench for idli_sqi_ctrl_m: per-cycle pin model derived from the transaction
// timeline, an SQI memory model driving read data, and literal spot checks.
module tb_idli_sqi_ctrl_m;
  import idli_pkg::*;

  localparam int LOGN = 4096;

  logic         gck = 1'b0;
  logic         rst_n = 1'b1;
  logic         vld = 1'b0, wr = 1'b0;
  logic [15:0]  addr = '0, wdata = '0;
  logic [3:0]   sio_in = '0;
  logic         rdy, rsp_vld, sqi_sck, sqi_cs;
  logic [15:0]  rdata;
  logic [3:0]   sio_out;
  sqi_io_mode_t mode;

  idli_sqi_ctrl_m dut (
    .i_sqi_gck(gck), .i_sqi_rst_n(rst_n),
    .i_sqi_req_vld(vld), .i_sqi_req_wr(wr), .i_sqi_req_addr(addr), .i_sqi_req_wdata(wdata),
    .o_sqi_req_rdy(rdy), .o_sqi_rsp_vld(rsp_vld), .o_sqi_rsp_rdata(rdata),
    .o_sqi_sck(sqi_sck), .o_sqi_cs(sqi_cs), .o_sqi_io_mode(mode),
    .i_sqi_sio(sio_in), .o_sqi_sio(sio_out)
  );

  always #5 gck = ~gck;

  int cyc = 0;
  always @(posedge gck) cyc <= cyc + 1;

  int checks = 0, failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return a ^ 16'hCAFF;
  endfunction

  // SQI memory: parses command/address on SCK rises, shifts read data out on SCK falls.
  int          mrise = 0;
  bit          msck = 1'b0;
  logic [7:0]  mcmd = '0;
  logic [23:0] maddr = '0;
  always @(sqi_sck or sqi_cs) begin
    int k;
    logic [15:0] w;
    if (sqi_cs) begin
      mrise = 0;
      msck  = 1'b0;
    end else begin
      if (sqi_sck && !msck) begin
        if (mrise < 2) mcmd = {mcmd[3:0], sio_out};
        else if (mrise < 8) maddr = {maddr[19:0], sio_out};
        mrise++;
      end else if (!sqi_sck && msck && mcmd == 8'h03 && mrise >= 10) begin
        k = mrise - 10;
        w = mem_word(maddr[16:1] + 16'(k / 4));
        sio_in = 4'(w >> (12 - 4 * (k % 4)));
      end
      msck = sqi_sck;
    end
  end

  typedef struct {
    bit cs; bit sck; bit rsp; bit rdy;
    bit chk_mode; sqi_io_mode_t mode;
    bit chk_sio; logic [3:0] sio;
    bit chk_rdata; logic [15:0] rdata;
  } exp_t;

  exp_t        exp_q[$];
  bit          m_hold = 1'b0, m_wr = 1'b0, m_acc = 1'b0;
  logic [15:0] m_addr = '0, m_rdata = '0;
  int          m_acc_cyc = 0;

  function automatic exp_t mk(input bit cs_, input bit sck_, input bit rsp_, input bit rdy_,
                              input bit cm, input sqi_io_mode_t md, input bit cs2, input logic [3:0] s);
    exp_t e;
    e.cs = cs_; e.sck = sck_; e.rsp = rsp_; e.rdy = rdy_;
    e.chk_mode = cm; e.mode = md; e.chk_sio = cs2; e.sio = s;
    e.chk_rdata = 1'b0; e.rdata = '0;
    return e;
  endfunction

  task automatic push_nib(input logic [3:0] n, input sqi_io_mode_t md, input bit c);
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, md, c, n));
    exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, md, c, n));
  endtask

  // Expected pin timeline for one accepted request, one entry per cycle.
  task automatic model_accept(input bit w, input logic [15:0] a, input logic [15:0] d);
    bit cont;
    logic [7:0] cm;
    logic [23:0] ba;
    exp_t e;
    cont = m_hold && (w == m_wr) && (32'(a) == 32'(m_addr) + 1);
    if (m_hold && !cont) exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, SQI_IO_MODE_OUT, 1'b0, 4'h0));
    if (!cont) begin
      cm = w ? 8'h02 : 8'h03;
      push_nib(cm[7:4], SQI_IO_MODE_OUT, 1'b1);
      push_nib(cm[3:0], SQI_IO_MODE_OUT, 1'b1);
      ba = {7'b0, a, 1'b0};
      for (int i = 5; i >= 0; i--) push_nib(4'(ba >> (4 * i)), SQI_IO_MODE_OUT, 1'b1);
      if (!w) for (int i = 0; i < DUMMY_NIB; i++) push_nib(4'h0, SQI_IO_MODE_IN, 1'b0);
    end
    for (int i = 3; i >= 0; i--)
      push_nib(w ? 4'(d >> (4 * i)) : 4'h0, w ? SQI_IO_MODE_OUT : SQI_IO_MODE_IN, w);
    if (!w) m_rdata = mem_word(a);
`ifdef IDLI_SQI_SEQ_EN
    e = mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, SQI_IO_MODE_OUT, 1'b0, 4'h0);
    m_hold = 1'b1;
`else
    e = mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, SQI_IO_MODE_OUT, 1'b0, 4'h0);
`endif
    e.chk_rdata = 1'b1;
    e.rdata = m_rdata;
    exp_q.push_back(e);
    m_wr = w;
    m_addr = a;
  endtask

  logic         cs_log [LOGN];
  logic         rsp_log [LOGN];
  logic         sck_log [LOGN];
  logic [15:0]  rdata_log [LOGN];
  sqi_io_mode_t mode_log [LOGN];
  logic [3:0]   nib_q[$];

  always @(negedge gck) begin
    exp_t e;
    if (!rst_n) begin
      exp_q.delete();
      m_hold = 1'b0;
      m_rdata = '0;
      m_acc = 1'b0;
    end else begin
      m_acc = 1'b0;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else begin
        e = mk(!m_hold, 1'b0, 1'b0, 1'b1, !m_hold, SQI_IO_MODE_OUT, 1'b0, 4'h0);
        e.chk_rdata = 1'b1;
        e.rdata = m_rdata;
      end
      chk("cs", 32'(sqi_cs), 32'(e.cs));
      chk("sck", 32'(sqi_sck), 32'(e.sck));
      chk("rsp_vld", 32'(rsp_vld), 32'(e.rsp));
      chk("req_rdy", 32'(rdy), 32'(e.rdy));
      if (e.chk_mode) chk("io_mode", 32'(mode), 32'(e.mode));
      if (e.chk_sio) chk("sio", 32'(sio_out), 32'(e.sio));
      if (e.chk_rdata) chk("rdata", 32'(rdata), 32'(e.rdata));
      if (vld && e.rdy) begin
        model_accept(wr, addr, wdata);
        m_acc = 1'b1;
        m_acc_cyc = cyc;
      end
    end
    if (cyc < LOGN) begin
      cs_log[cyc] = sqi_cs; rsp_log[cyc] = rsp_vld; sck_log[cyc] = sqi_sck;
      rdata_log[cyc] = rdata; mode_log[cyc] = mode;
    end
    if (sqi_sck && !sqi_cs && mode == SQI_IO_MODE_OUT) nib_q.push_back(sio_out);
  end

  int last_acc = 0;

  task automatic req(input bit w, input logic [15:0] a, input logic [15:0] d, input bit keep);
    int n = 0;
    vld = 1'b1; wr = w; addr = a; wdata = d;
    do begin
      @(posedge gck); #1;
      n++;
    end while (!m_acc && n < 200);
    if (!m_acc) begin
      checks++; failures++;
      $display("FAIL accept_timeout addr=%0h got=no_accept want=accept", a);
    end
    last_acc = m_acc_cyc;
    if (!keep) vld = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge gck); #1; end
  endtask

  task automatic chk_nibs(input string nm, input logic [47:0] expv, input int n);
    chk({nm, "_count"}, 32'(nib_q.size()), 32'(n));
    for (int i = 0; i < n && i < nib_q.size(); i++)
      chk(nm, 32'(nib_q[i]), 32'(4'(expv >> (4 * (n - 1 - i)))));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    int a, a2, a3, s;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_cs", 32'(sqi_cs), 32'd1);
    chk("rst_sck", 32'(sqi_sck), 32'd0);
    chk("rst_mode", 32'(mode), 32'(SQI_IO_MODE_OUT));
    chk("rst_sio", 32'(sio_out), 32'd0);
    chk("rst_rsp", 32'(rsp_vld), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_rdy", 32'(rdy), 32'd1);
    repeat (3) @(posedge gck);
    #1 rst_n = 1'b1;
    idle(2);

    // Write 1234 <- BEEF
    nib_q.delete();
    req(1'b1, 16'h1234, 16'hBEEF, 1'b0);
    a = last_acc;
    idle(30);
    chk_nibs("wr_nibs", 48'h0200_2468_BEEF, 12);
    chk("wr_rsp_c24", 32'(rsp_log[a + 24]), 32'd0);
    chk("wr_rsp_c25", 32'(rsp_log[a + 25]), 32'd1);
    chk("wr_cs_c1", 32'(cs_log[a + 1]), 32'd0);

    // Read 0001, memory returns CAFE
    nib_q.delete();
    req(1'b0, 16'h0001, 16'h0000, 1'b0);
    a = last_acc;
    idle(34);
    chk_nibs("rd_nibs", 48'h0000_0300_0002, 8);
    chk("rd_mode_c16", 32'(mode_log[a + 16]), 32'(SQI_IO_MODE_OUT));
    chk("rd_mode_c17", 32'(mode_log[a + 17]), 32'(SQI_IO_MODE_IN));
    chk("rd_rsp_c29", 32'(rsp_log[a + 29]), 32'd1);
    chk("rd_rdata_c29", 32'(rdata_log[a + 29]), 32'hCAFE);

`ifndef IDLI_SQI_SEQ_EN
    // Back-to-back write then read with vld held high
    req(1'b1, 16'h0100, 16'h5A5A, 1'b1);
    a = last_acc;
    req(1'b0, 16'h0002, 16'h0000, 1'b0);
    a2 = last_acc;
    idle(32);
    chk("b2b_gap", 32'(a2 - a), 32'd26);
    chk("b2b_cs_c24", 32'(cs_log[a + 24]), 32'd0);
    chk("b2b_cs_c25", 32'(cs_log[a + 25]), 32'd1);
    chk("b2b_cs_c26", 32'(cs_log[a + 26]), 32'd1);
    chk("b2b_cs_c27", 32'(cs_log[a + 27]), 32'd0);
    chk("b2b_rdata", 32'(rdata_log[a2 + 29]), 32'hCAFD);
`else
    // Sequential read 0010 then 0011, then non-contiguous 0005
    req(1'b0, 16'h0010, 16'h0000, 1'b0);
    a = last_acc;
    idle(34);
    chk("seq_rd0_rdata", 32'(rdata_log[a + 30]), 32'hCAEF);
    nib_q.delete();
    req(1'b0, 16'h0011, 16'h0000, 1'b0);
    a2 = last_acc;
    idle(12);
    chk("seq_rd1_rsp", 32'(rsp_log[a2 + 9]), 32'd1);
    chk("seq_rd1_rdata", 32'(rdata_log[a2 + 9]), 32'hCAEE);
    chk("seq_rd1_out_nibs", 32'(nib_q.size()), 32'd0);
    s = 0;
    for (int c = a2 + 1; c <= a2 + 9; c++) s += int'(sck_log[c]);
    chk("seq_rd1_sck_rises", 32'(s), 32'd4);
    s = 0;
    for (int c = a + 2; c <= a2 + 9; c++) s += int'(cs_log[c]);
    chk("seq_cs_low_run", 32'(s), 32'd0);
    nib_q.delete();
    req(1'b0, 16'h0005, 16'h0000, 1'b0);
    a3 = last_acc;
    idle(34);
    chk("seq_csh_c1", 32'(cs_log[a3 + 1]), 32'd1);
    chk("seq_csh_c2", 32'(cs_log[a3 + 2]), 32'd0);
    chk_nibs("seq_rd2_nibs", 48'h0000_0300_000A, 8);
    chk("seq_rd2_rdata", 32'(rdata_log[a3 + 30]), 32'hCAFA);
    // FFFF then 0000 is not contiguous
    req(1'b1, 16'hFFFF, 16'h1111, 1'b0);
    idle(30);
    nib_q.delete();
    req(1'b1, 16'h0000, 16'h2222, 1'b0);
    a = last_acc;
    idle(32);
    chk("seq_wrap_csh", 32'(cs_log[a + 1]), 32'd1);
    chk_nibs("seq_wrap_nibs", 48'h0200_0000_2222, 12);
`endif

    // Reset during cycle 10 of a read: CS must rise at once, no response follows
    req(1'b0, 16'h0003, 16'h0000, 1'b0);
    a = last_acc;
    while (cyc < a + 10) @(posedge gck);
    #2;
    chk("mid_cs_before", 32'(sqi_cs), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cs", 32'(sqi_cs), 32'd1);
    chk("mid_rst_rsp", 32'(rsp_vld), 32'd0);
    repeat (2) @(posedge gck);
    #3 rst_n = 1'b1;
    idle(40);
    s = 0;
    for (int c = a + 10; c <= a + 45; c++) s += int'(rsp_log[c]);
    chk("mid_rst_no_rsp", 32'(s), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
